// File: rtl/tl_pkg.sv
// Shared definitions for the timed traffic light controller:
// phase encoding, sensor bit positions and a printable phase-name helper.
package tl_pkg;

  // 3-bit phase encoding seen on the state output (111 is never driven)
  localparam logic [2:0] ST_RR = 3'b000;
  localparam logic [2:0] ST_GR = 3'b001;
  localparam logic [2:0] ST_LR = 3'b010;
  localparam logic [2:0] ST_YR = 3'b011;
  localparam logic [2:0] ST_RG = 3'b100;
  localparam logic [2:0] ST_RL = 3'b101;
  localparam logic [2:0] ST_RY = 3'b110;

  typedef enum logic [2:0] {
    S_RR = ST_RR,
    S_GR = ST_GR,
    S_LR = ST_LR,
    S_YR = ST_YR,
    S_RG = ST_RG,
    S_RL = ST_RL,
    S_RY = ST_RY
  } tl_state_t;

  // Sensor bit positions
  localparam int SNS_MAIN_THRU = 3;
  localparam int SNS_MAIN_LEFT = 2;
  localparam int SNS_SIDE_THRU = 1;
  localparam int SNS_SIDE_LEFT = 0;

  // Two-character ASCII name of a phase code, for messages
  function automatic logic [15:0] state_name(input logic [2:0] s);
    logic [15:0] n;
    case (s)
      ST_RR:   n = "RR";
      ST_GR:   n = "GR";
      ST_LR:   n = "LR";
      ST_YR:   n = "YR";
      ST_RG:   n = "RG";
      ST_RL:   n = "RL";
      ST_RY:   n = "RY";
      default: n = "??";
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tl_rr_arbiter.sv
// Four-request round-robin arbiter. Search order is 3->2->1->0->3 starting
// at the pointer; the pointer moves to the bit after the winner only when
// the grant is taken (i_en high).
module tl_rr_arbiter
  import tl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] i_req,
  input  logic       i_en,
  output logic [3:0] o_grant
);

  logic [1:0] r_ptr;
  logic [1:0] w_idx;
  logic [1:0] w_gidx;
  logic       w_found;

  // Pick the first requester walking downward (with wrap) from the pointer
  always_comb begin
    o_grant = 4'b0000;
    w_found = 1'b0;
    w_gidx  = r_ptr;
    w_idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      w_idx = r_ptr - 2'(k);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_gidx  = w_idx;
      end
    end
    if (w_found) o_grant[w_gidx] = 1'b1;
  end

  // Advance the pointer past the winner when the grant is consumed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= 2'(SNS_MAIN_THRU);
    end else if (i_en && w_found) begin
      r_ptr <= w_gidx - 2'd1;
    end
  end

endmodule

// File: rtl/traffic_light_controller_timed.sv
// Timed four-approach traffic light controller: min/max green, fixed
// yellow, all-red clearance with round-robin grant, and a freeze input.
module traffic_light_controller_timed
  import tl_pkg::*;
#(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 16,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 2,
  parameter int TW        = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [3:0]    sensor,
  input  logic          hold,
  output logic [2:0]    state,
  output logic [TW-1:0] phase_cnt,
  output logic          phase_start
);

  // Last counter value of each timed window
  localparam logic [TW-1:0] L_MIN_LAST = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] L_MAX_LAST = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] L_YEL_LAST = TW'(YELLOW - 1);
  localparam logic [TW-1:0] L_AR_LAST  = TW'(ALL_RED - 1);

  tl_state_t     r_state;
  tl_state_t     w_next;
  logic [TW-1:0] r_cnt;
  logic          r_start;
  logic          w_exit;
  logic          w_grant_en;
  logic [3:0]    w_grant;

  // A green ends once min time is served and its own request has dropped
  // or someone else is waiting, or unconditionally at max time.
  function automatic logic green_done(input logic [3:0] s, input logic [1:0] b,
                                      input logic [TW-1:0] c);
    logic own;
    logic others;
    own    = s[b];
    others = |(s & ~(4'b0001 << b));
    return ((c >= L_MIN_LAST) && (!own || others)) || (c == L_MAX_LAST);
  endfunction

  tl_rr_arbiter u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req   (sensor),
    .i_en    (w_grant_en),
    .o_grant (w_grant)
  );

  // Next-state decision; hold suppresses every transition and grant
  always_comb begin
    w_next     = r_state;
    w_exit     = 1'b0;
    w_grant_en = 1'b0;
    if (!hold) begin
      case (r_state)
        S_GR: if (green_done(sensor, 2'd3, r_cnt)) begin w_exit = 1'b1; w_next = S_YR; end
        S_LR: if (green_done(sensor, 2'd2, r_cnt)) begin w_exit = 1'b1; w_next = S_YR; end
        S_RG: if (green_done(sensor, 2'd1, r_cnt)) begin w_exit = 1'b1; w_next = S_RY; end
        S_RL: if (green_done(sensor, 2'd0, r_cnt)) begin w_exit = 1'b1; w_next = S_RY; end
        S_YR, S_RY: begin
          if (r_cnt == L_YEL_LAST) begin
            w_exit = 1'b1;
            w_next = S_RR;
          end
        end
        S_RR: begin
          if ((r_cnt >= L_AR_LAST) && (sensor != 4'b0000)) begin
            w_exit     = 1'b1;
            w_grant_en = 1'b1;
            case (w_grant)
              4'b1000: w_next = S_GR;
              4'b0100: w_next = S_LR;
              4'b0010: w_next = S_RG;
              default: w_next = S_RL;
            endcase
          end
        end
        default: begin
          w_exit = 1'b1;
          w_next = S_RR;
        end
      endcase
    end
  end

  // State, dwell counter and entry strobe; RR counter saturates while idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_RR;
      r_cnt   <= '0;
      r_start <= 1'b0;
    end else if (hold) begin
      r_start <= 1'b0;
    end else if (w_exit) begin
      r_state <= w_next;
      r_cnt   <= '0;
      r_start <= 1'b1;
    end else begin
      r_start <= 1'b0;
      if (!((r_state == S_RR) && (r_cnt >= L_AR_LAST))) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign state       = r_state;
  assign phase_cnt   = r_cnt;
  assign phase_start = r_start;

endmodule

// File: doc/traffic_light_controller_timed.md
# traffic_light_controller_timed

Parametrised, timed successor to the single-cycle 4-sensor traffic light controller. It keeps the same 3-bit phase encoding and sensor meaning. It adds programmable minimum/maximum green, yellow and all-red clearance durations, mandatory yellow and all-red between greens, round-robin fairness among pending approaches, and a hold (freeze) input. It sits between the intersection sensor front end and the lamp driver decode.

## Interface
- MIN_GREEN, 4, minimum cycles any green/left phase is held (≥1)
- MAX_GREEN, 16, maximum cycles a green/left phase is held (≥MIN_GREEN)
- YELLOW, 3, cycles in YR/RY (≥1)
- ALL_RED, 2, minimum cycles in RR clearance (≥1)
- TW, 8, width of phase counter; must hold max(MAX_GREEN,YELLOW,ALL_RED)-1
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- sensor  in  4  requests: [3] main through, [2] main left, [1] side through, [0] side left
- hold  in  1  freeze state and counter while high
- state  out  3  000 RR, 001 GR, 010 LR, 011 YR, 100 RG, 101 RL, 110 RY; 111 never driven
- phase_cnt  out  TW  cycles elapsed in current state, 0 on its first cycle
- phase_start  out  1  high for the first cycle of each state entered by transition

## Operation
- Reset (async assert): state=RR, phase_cnt=0, phase_start=0, round-robin pointer set so search begins at sensor[3].
- Green phases: GR (sensor[3]), LR ([2]), RG ([1]), RL ([0]). "own" is the phase's sensor bit. "others" is any other sensor bit.
- Green exit at the edge where (phase_cnt ≥ MIN_GREEN-1 and (!own or others)) or phase_cnt == MAX_GREEN-1.
- GR/LR exit to YR. RG/RL exit to RY.
- YR/RY exit to RR at phase_cnt == YELLOW-1.
- RR exit occurs at an edge where phase_cnt ≥ ALL_RED-1 and sensor ≠ 0000. Otherwise RR is held indefinitely and phase_cnt saturates at ALL_RED-1.
- RR grant is round-robin: search order 3→2→1→0→3, starting at the bit after the last granted. The grant is computed from sensor sampled at the exit edge.
- Pointer updates only on a grant. A single persistent requester is re-granted after max-out.
- hold=1: state, phase_cnt and pointer are frozen, and phase_start=0. On release, operation continues from the frozen values.
- sensor may change every cycle. Only values at decision edges matter. There is no latching of brief requests.

## Timing
- All outputs are registered; the state change is visible 1 cycle after the deciding edge.
- Green dwell is between MIN_GREEN and MAX_GREEN cycles. Yellow dwell is exactly YELLOW. RR dwell is ≥ ALL_RED.
- Minimum green-to-green gap is YELLOW+ALL_RED cycles.
- Simultaneous hold and exit condition: hold wins, and there is no transition.
- reset_n asserted mid-phase takes effect immediately. After release, RR clearance restarts from phase_cnt=0.
- phase_cnt resets to 0 on every transition and otherwise increments by 1 per unheld cycle. It never wraps given TW is sized correctly.

## Structure
- Shared package tl_pkg holds:
  - state encoding localparams (ST_RR…ST_RY)
  - sensor index constants
  - the state-name decode function used by benches
- One sub-module, tl_rr_arbiter: 4-request round-robin grant with pointer register, enable=grant strobe. The FSM and counter live in the top.

## Test plan
All scenarios use default parameters.
- reset_n low during GR at phase_cnt=5 → state=000 and phase_cnt=0 immediately. With sensor=0000 after release, state stays RR for 50 cycles.
- sensor=1000 constant from reset → RR 2, GR 16, YR 3, RR 2, GR 16 (phase_start pulses at each entry).
- sensor=1000, then 1010 from GR phase_cnt=1 → GR held 4 cycles, YR 3, RR 2, then RG.
- sensor=1111 constant → GR, LR, RG, RL in order, each 4 cycles, each separated by yellow 3 + RR 2, then GR again.
- sensor=0001 for one cycle at the RR exit edge, then 0000 → RL held exactly 4 cycles, RY 3, RR.
- hold=1 for 5 cycles during YR at phase_cnt=1 → state=YR and phase_cnt=1 frozen. After release, YR finishes 2 more cycles, then RR.
